serial_adder_32: RTL and testbench

Multi-cycle bit-serial adder: the addition counterpart to the team's combinational 32-bit full subtractor. It trades latency for area by resolving STEP bits per clock, LSB first, behind a start/busy/done handshake. Intended for the adder/subtractor exercise set, where its results are checked against the combinational subtractor, e.g. x + y then (x + y) − y.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/adder_chunk.sv | 27 ++
 rtl/serial_adder_32.sv | 166 ++++++++++++++++
 tb/tb_serial_adder_32.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder family: FSM states, default
// geometry and the counter-width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 32;
    localparam int STEP_DEF  = 1;

    // Ceiling log2, never less than 1 so a counter always has a bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational STEP-bit ripple adder built from single-bit full adders.
// c_msb exposes the carry into the top bit so the caller can form signed
// overflow on the final chunk.
module adder_chunk #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] a,
    input  logic [STEP-1:0] b,
    input  logic            ci,
    output logic [STEP-1:0] sum,
    output logic            co,
    output logic            c_msb
);

    logic [STEP:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < STEP; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c_s[i];
        assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end

    assign co    = c_s[STEP];
    assign c_msb = c_s[STEP-1];

endmodule

// File: rtl/serial_adder_32.sv
// Bit-serial adder: resolves STEP bits per clock, LSB first, behind a
// start/busy/done handshake. Results are registered and held until the
// next operation completes.
module serial_adder_32
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEP  = STEP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int              N        = WIDTH / STEP;
    localparam int              CNT_W    = clog2_min1(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] x_sh_r;
    logic [WIDTH-1:0] y_sh_r;
    logic [WIDTH-1:0] s_sh_r;
    logic             carry_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             last_s;
    logic [STEP-1:0]  sum_chunk_s;
    logic             chunk_co_s;
    logic             chunk_cmsb_s;
    logic [WIDTH-1:0] s_shift_s;

    adder_chunk #(
        .STEP (STEP)
    ) u_chunk (
        .a     (x_sh_r[STEP-1:0]),
        .b     (y_sh_r[STEP-1:0]),
        .ci    (carry_r),
        .sum   (sum_chunk_s),
        .co    (chunk_co_s),
        .c_msb (chunk_cmsb_s)
    );

    // New chunk enters at the top; after N shifts chunk 0 sits at the LSBs.
    assign s_shift_s = {sum_chunk_s, s_sh_r[WIDTH-1:STEP]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus accept/last-chunk strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                // Back-to-back issue is accepted straight from DONE.
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand and partial-sum shift registers, carry register and chunk counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_sh_r  <= {WIDTH{1'b0}};
            y_sh_r  <= {WIDTH{1'b0}};
            s_sh_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else if (accept_s) begin
            x_sh_r  <= x;
            y_sh_r  <= y;
            carry_r <= cin;
            cnt_r   <= CNT_ZERO;
        end else if (state_r == RUN) begin
            x_sh_r  <= x_sh_r >> STEP;
            y_sh_r  <= y_sh_r >> STEP;
            s_sh_r  <= s_shift_s;
            carry_r <= chunk_co_s;
            cnt_r   <= cnt_r + CNT_ONE;
        end else begin
            x_sh_r  <= x_sh_r;
            y_sh_r  <= y_sh_r;
            s_sh_r  <= s_sh_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    // Registered handshake and result outputs; results move only on the last chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            s_r    <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= (state_next_s == RUN);
            done_r <= (state_next_s == DONE);
            if (last_s) begin
                s_r    <= s_shift_s;
                cout_r <= chunk_co_s;
                ovf_r  <= chunk_cmsb_s ^ chunk_co_s;
            end else begin
                s_r    <= s_r;
                cout_r <= cout_r;
                ovf_r  <= ovf_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder_32.sv
// Directed + randomized bench for serial_adder_32 (STEP = 1 and STEP = 4).
module tb_serial_adder_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        cout;
    logic        ovf;

    logic        start4;
    logic [31:0] x4;
    logic [31:0] y4;
    logic        cin4;
    logic        busy4;
    logic        done4;
    logic [31:0] s4;
    logic        cout4;
    logic        ovf4;

    int n_tests = 0;
    int n_fail  = 0;

    serial_adder_32 #(.WIDTH(32), .STEP(1)) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .x (x), .y (y), .cin (cin),
        .busy (busy), .done (done), .s (s), .cout (cout), .ovf (ovf)
    );

    serial_adder_32 #(.WIDTH(32), .STEP(4)) dut4 (
        .clk (clk), .rst_n (rst_n), .start (start4), .x (x4), .y (y4), .cin (cin4),
        .busy (busy4), .done (done4), .s (s4), .cout (cout4), .ovf (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide addition; overflow from operand/result signs.
    function automatic logic [33:0] add_model(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] full;
        logic        v;
        full = {1'b0, a} + {1'b0, b} + {32'd0, c};
        v    = (a[31] == b[31]) && (full[31] != a[31]);
        return {v, full[32], full[31:0]};
    endfunction

    // Issue one op on the STEP=1 DUT, optionally pulse start mid-RUN, wait for done.
    task automatic run_op(input logic [31:0] ax, input logic [31:0] ay, input logic acin,
                          input bit inject_mid, input string tag);
        logic [33:0] m;
        int          cyc;
        m     = add_model(ax, ay, acin);
        x     = ax;
        y     = ay;
        cin   = acin;
        start = 1'b1;
        tick();
        start = 1'b0;
        x     = $urandom;
        y     = $urandom;
        cin   = 1'($urandom_range(0, 1));
        check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!done && cyc < 100) begin
            if (inject_mid && cyc == 10) begin
                start = 1'b1;
                x     = ~ax;
                y     = ay ^ 32'h5A5A_5A5A;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'd32);
        check({tag, " s"}, 64'(s), 64'(m[31:0]));
        check({tag, " cout"}, 64'(cout), 64'(m[32]));
        check({tag, " ovf"}, 64'(ovf), 64'(m[33]));
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [33:0] m;
        logic [31:0] xs;
        logic [31:0] ys;
        int          cyc;
        int          done_cnt;

        rst_n  = 1'b0;
        start  = 1'b0;
        x      = 32'h0;
        y      = 32'h0;
        cin    = 1'b0;
        start4 = 1'b0;
        x4     = 32'h0;
        y4     = 32'h0;
        cin4   = 1'b0;

        // Reset held 3 cycles with start pulsed during it.
        start = 1'b1;
        x     = 32'h1234_5678;
        y     = 32'h1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset busy", 64'(busy), 64'd0);
            check("reset done", 64'(done), 64'd0);
            check("reset s", 64'(s), 64'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset idle busy", 64'(busy), 64'd0);
            check("post_reset idle done", 64'(done), 64'd0);
        end

        // Basic add and hold after done.
        run_op(32'h0000_0005, 32'h0000_0001, 1'b0, 1'b0, "basic");
        check("basic s_exact", 64'(s), 64'h6);
        tick();
        check("hold done_pulse", 64'(done), 64'd0);
        check("hold s", 64'(s), 64'h6);

        // Carry and overflow corners, with literal expectations.
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "wrap");
        check("wrap lit", 64'({ovf, cout, s}), {30'd0, 1'b0, 1'b1, 32'h0});
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "posovf");
        check("posovf lit", 64'({ovf, cout, s}), {30'd0, 1'b1, 1'b0, 32'h8000_0000});
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "negovf");
        check("negovf lit", 64'({ovf, cout, s}), {30'd0, 1'b1, 1'b1, 32'h0});

        // Subtraction by caller, checked against plain difference.
        for (int k = 0; k < 10; k++) begin
            xs = 32'd50 + 32'(5 * k);
            ys = 32'd10 + 32'(k);
            run_op(xs, ~ys, 1'b1, 1'b0, "sub");
            check("sub diff", 64'(s), 64'(xs - ys));
            check("sub no_borrow", 64'(cout), 64'(xs >= ys));
        end

        // Random adds.
        for (int k = 0; k < 8; k++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        // start pulsed mid-RUN is ignored.
        run_op(32'h0102_0304, 32'h1111_2222, 1'b0, 1'b1, "midstart");

        // Back-to-back: start held on the DONE cycle.
        run_op(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, "b2b_first");
        m     = add_model(32'hCAFE_1234, 32'h4321_0FED, 1'b1);
        x     = 32'hCAFE_1234;
        y     = 32'h4321_0FED;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("b2b spacing", 64'(cyc), 64'd33);
        check("b2b s", 64'(s), 64'(m[31:0]));
        check("b2b cout", 64'(cout), 64'(m[32]));

        // Abort by reset at cycle 10 of RUN.
        x     = 32'h0F0F_0F0F;
        y     = 32'h1010_1010;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort s", 64'(s), 64'd0);
        check("abort cout", 64'(cout), 64'd0);
        check("abort ovf", 64'(ovf), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort no_done", 64'(done_cnt), 64'd0);

        // STEP = 4 instance: directed then random.
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                x4   = 32'h1234_5678;
                y4   = 32'h1111_1111;
                cin4 = 1'b0;
            end else begin
                x4   = $urandom;
                y4   = $urandom;
                cin4 = 1'($urandom_range(0, 1));
            end
            m      = add_model(x4, y4, cin4);
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            x4     = $urandom;
            y4     = $urandom;
            cyc    = 0;
            while (!done4 && cyc < 100) begin
                tick();
                cyc++;
            end
            check("step4 latency", 64'(cyc), 64'd8);
            check("step4 s", 64'(s4), 64'(m[31:0]));
            check("step4 cout", 64'(cout4), 64'(m[32]));
            check("step4 ovf", 64'(ovf4), 64'(m[33]));
            if (k == 0) check("step4 lit", 64'(s4), 64'h2345_6789);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
